// File: rtl/rf_wb_if.sv
// rf_wb_if: valid/ready writeback handshake for requesters A (ALU) and B (memory load)
interface rf_wb_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          a_valid;
  logic          a_ready;
  logic [AW-1:0] a_rw;
  logic [DW-1:0] a_data;
  logic          b_valid;
  logic          b_ready;
  logic [AW-1:0] b_rw;
  logic [DW-1:0] b_data;
  modport master (
    output a_valid, a_rw, a_data, b_valid, b_rw, b_data,
    input  a_ready, b_ready
  );
  modport slave (
    input  a_valid, a_rw, a_data, b_valid, b_rw, b_data,
    output a_ready, b_ready
  );
endinterface

// File: rtl/rf_wb_ctrl.sv
// rf_wb_ctrl: register file write port, clear pass after reset then round-robin A/B writeback
module rf_wb_ctrl #(
  parameter int DW   = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  rf_wb_if.slave        wb,
  output logic          rf_we,
  output logic [AW-1:0] rf_rw,
  output logic [DW-1:0] rf_busw,
  output logic          init_done
);
  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] RUN   = 1'b1;
  logic [0:0]    state;
  logic [AW:0]   clr_idx;
  logic          rr_ptr;
  logic          run;
  logic          a_xfer;
  logic          b_xfer;
  logic [AW-1:0] sel_rw;
  logic [DW-1:0] sel_data;
  // rr_ptr: 0 favours A, 1 favours B when both are valid
  always_comb begin
    run        = state == RUN;
    wb.a_ready = run & wb.a_valid & (~wb.b_valid | ~rr_ptr);
    wb.b_ready = run & wb.b_valid & (~wb.a_valid | rr_ptr);
    a_xfer     = wb.a_valid & wb.a_ready;
    b_xfer     = wb.b_valid & wb.b_ready;
    sel_rw     = a_xfer ? wb.a_rw : wb.b_rw;
    sel_data   = a_xfer ? wb.a_data : wb.b_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      clr_idx   <= '0;
      rr_ptr    <= 1'b0;
      rf_we     <= 1'b0;
      rf_rw     <= '0;
      rf_busw   <= '0;
      init_done <= 1'b0;
    end else if (state == CLEAR) begin
      rf_we   <= 1'b1;
      rf_rw   <= clr_idx[AW-1:0];
      rf_busw <= '0;
      clr_idx <= clr_idx + 1'b1;
      if (clr_idx == (AW+1)'(NREG-1)) begin
        state     <= RUN;
        init_done <= 1'b1;
      end
    end else begin
      rf_we <= (a_xfer | b_xfer) & (sel_rw != '0);
      if (a_xfer | b_xfer) rr_ptr <= a_xfer;
      // register 0 writes are swallowed: accepted but the port keeps its last index/data
      if ((a_xfer | b_xfer) & (sel_rw != '0)) begin
        rf_rw   <= sel_rw;
        rf_busw <= sel_data;
      end
    end
  end
endmodule
